// File: rtl/des_pkg.sv
// Shared constants, bit-index tables and permutation helpers for the DES decrypt core.
// All tables use DES numbering: entry n names source bit n, bit 1 being the MSB.
package des_pkg;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam int unsigned ROUNDS = 16;

  // Right-rotation applied to C/D before PC2 for decrypt rounds 1..16 (K16 down to K1).
  localparam logic [1:0] SHIFT_SCHED [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  localparam logic [6:0] IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam logic [6:0] FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};

  localparam logic [5:0] E_TAB [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};

  localparam logic [5:0] P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};

  localparam logic [6:0] PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};

  localparam logic [5:0] PC2_TAB [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // S-box contents, each box stored row-major (row * 16 + column).
  localparam logic [3:0] SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Each helper builds the output MSB-first, pulling DES bit n from position (width - n).
  function automatic logic [63:0] ip_perm(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], 1'(x >> (7'd64 - IP_TAB[6'(i)]))};
    return y;
  endfunction

  function automatic logic [63:0] fp_perm(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = {y[62:0], 1'(x >> (7'd64 - FP_TAB[6'(i)]))};
    return y;
  endfunction

  function automatic logic [47:0] e_exp(input logic [31:0] x);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], 1'(x >> (6'd32 - E_TAB[6'(i)]))};
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y = '0;
    for (int i = 0; i < 32; i++) y = {y[30:0], 1'(x >> (6'd32 - P_TAB[5'(i)]))};
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input logic [63:0] x);
    logic [55:0] y = '0;
    for (int i = 0; i < 56; i++) y = {y[54:0], 1'(x >> (7'd64 - PC1_TAB[6'(i)]))};
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y = '0;
    for (int i = 0; i < 48; i++) y = {y[46:0], 1'(x >> (6'd56 - PC2_TAB[6'(i)]))};
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] v, input logic [1:0] n);
    case (n)
      2'd1:    return {v[0], v[27:1]};
      2'd2:    return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/des_round_f.sv
// DES Feistel f-function: expansion, key mix, eight S-boxes, P permutation.
module des_sbox
  import des_pkg::*;
#(
  parameter logic [2:0] IDX = 3'd0
) (
  input  logic [5:0] b,
  output logic [3:0] s
);
  // Row comes from the outer bits, column from the inner four.
  assign s = SBOX[IDX][{b[5], b[0], b[4:1]}];
endmodule

module des_round_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);
  logic [47:0] x;
  logic [31:0] s;

  assign x = e_exp(r) ^ k;

  des_sbox #(.IDX(3'd0)) s_box_1 (.b(x[47:42]), .s(s[31:28]));
  des_sbox #(.IDX(3'd1)) s_box_2 (.b(x[41:36]), .s(s[27:24]));
  des_sbox #(.IDX(3'd2)) s_box_3 (.b(x[35:30]), .s(s[23:20]));
  des_sbox #(.IDX(3'd3)) s_box_4 (.b(x[29:24]), .s(s[19:16]));
  des_sbox #(.IDX(3'd4)) s_box_5 (.b(x[23:18]), .s(s[15:12]));
  des_sbox #(.IDX(3'd5)) s_box_6 (.b(x[17:12]), .s(s[11:8]));
  des_sbox #(.IDX(3'd6)) s_box_7 (.b(x[11:6]),  .s(s[7:4]));
  des_sbox #(.IDX(3'd7)) s_box_8 (.b(x[5:0]),   .s(s[3:0]));

  assign f = p_perm(s);
endmodule

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption core: one Feistel round per clock, valid/ready on both sides.
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic [63:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
);
  state_t      state, state_next;
  logic [31:0] l, r, f;
  logic [27:0] c, d, c_rot, d_rot;
  logic [4:0]  cnt;
  logic [1:0]  shamt;
  logic [47:0] subkey;
  logic        last_round;

  // Key schedule runs backwards: rotate right, so round 1 sees the unrotated C0/D0 (K16).
  assign shamt      = SHIFT_SCHED[4'(cnt - 5'd1)];
  assign c_rot      = rotr28(c, shamt);
  assign d_rot      = rotr28(d, shamt);
  assign subkey     = pc2_perm({c_rot, d_rot});
  assign last_round = (cnt == 5'(ROUNDS));

  des_round_f u_round_f (.r(r), .k(subkey), .f(f));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ROUND;
      end
      ROUND: if (last_round) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, one round per cycle, capture the plaintext on the last round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l        <= '0;
      r        <= '0;
      c        <= '0;
      d        <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          {l, r} <= ip_perm(in_data);
          {c, d} <= pc1_perm(in_key);
          cnt    <= 5'd1;
        end
        ROUND: begin
          l <= r;
          r <= l ^ f;
          c <= c_rot;
          d <= d_rot;
          // Halves swap before FP: R16 = L15 ^ f, L16 = R15.
          if (last_round) out_data <= fp_perm({l ^ f, r});
          else            cnt      <= cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Self-checking bench for des_decrypt_core: known answers, stall, reset abort, back-to-back, random.
module tb_des_decrypt_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [63:0] in_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2 = 64'h0000000000000000;
  localparam logic [63:0] P2 = 64'h8787878787878787;

  des_decrypt_core dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Reference DES tables (FP is derived by inverting IP).
  int ip_t [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  int e_t [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
                   12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                   24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  int p_t [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                   2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  int pc1_t [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                     10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                     14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int pc2_t [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                     23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int sb [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // DES bit p (1 = MSB) of a w-bit value held LSB-aligned, returned in bit 0.
  function automatic logic [63:0] pick(input logic [63:0] v, input int w, input int p);
    logic [63:0] t;
    t = v >> (w - p);
    return {63'b0, t[0]};
  endfunction

  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] y = '0;
    for (int i = 0; i < 64; i++) y = y | (pick(x, 64, i + 1) << (64 - ip_t[6'(i)]));
    return y;
  endfunction

  // Textbook DES: left-rotating encryption schedule, subkeys reversed for decryption.
  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] blk,
                                            input bit dec);
    logic [47:0] ks [16];
    logic [27:0] c, d;
    logic [63:0] t;
    logic [31:0] l, r, tmp, s;
    logic [47:0] x;
    int b6, row, col;
    t = '0;
    for (int i = 0; i < 56; i++) t = (t << 1) | pick(key, 64, pc1_t[6'(i)]);
    c = t[55:28];
    d = t[27:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      for (int n = 0; n < ((rnd == 0 || rnd == 1 || rnd == 8 || rnd == 15) ? 1 : 2); n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = '0;
      for (int i = 0; i < 48; i++) t = (t << 1) | pick({8'h0, c, d}, 56, pc2_t[6'(i)]);
      ks[4'(rnd)] = t[47:0];
    end
    t = '0;
    for (int i = 0; i < 64; i++) t = (t << 1) | pick(blk, 64, ip_t[6'(i)]);
    l = t[63:32];
    r = t[31:0];
    for (int rnd = 0; rnd < 16; rnd++) begin
      t = '0;
      for (int i = 0; i < 48; i++) t = (t << 1) | pick({32'h0, r}, 32, e_t[6'(i)]);
      x = t[47:0] ^ ks[4'(dec ? 15 - rnd : rnd)];
      s = '0;
      for (int j = 0; j < 8; j++) begin
        b6  = int'(x >> (42 - 6 * j)) & 63;
        row = ((b6 >> 4) & 2) | (b6 & 1);
        col = (b6 >> 1) & 15;
        s   = (s << 4) | sb[3'(j)][6'(row * 16 + col)];
      end
      t = '0;
      for (int i = 0; i < 32; i++) t = (t << 1) | pick({32'h0, s}, 32, p_t[5'(i)]);
      tmp = r;
      r   = l ^ t[31:0];
      l   = tmp;
    end
    return ip_inv({r, l});
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pair, wait for the result, hold it for 'stall' cycles, then take it.
  task automatic xfer(input logic [63:0] key, input logic [63:0] data, input int stall,
                      output logic [63:0] res, output int lat);
    int n = 0;
    in_key   = key;
    in_data  = data;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    check_val("accept_ready", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
    in_key   = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    res = out_data;
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, exp, k, dt;
    int lat, seen, nacc;
    logic [63:0] res_q [$];
    int cyc_q [$];
    bit acc;

    // Reset values
    repeat (3) tick();
    check_val("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    check_val("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check_val("rst_out_data_after", out_data, 64'd0);

    // Known answers with latency
    xfer(K1, C1, 0, res, lat);
    check_val("kat1_data", res, P1);
    check_val("kat1_latency", 64'(lat), 64'd16);
    xfer(K2, C2, 0, res, lat);
    check_val("kat2_data", res, P2);
    check_val("kat2_latency", 64'(lat), 64'd16);

    // Held result under back-pressure; competing in_valid ignored
    in_key = K1; in_data = C1; in_valid = 1'b1;
    tick();
    in_key = K2; in_data = C2;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check_val("stall_first", out_data, P1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("stall_valid", {63'b0, out_valid}, 64'd1);
      check_val("stall_data", out_data, P1);
      check_val("stall_in_ready", {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("stall_release", {63'b0, out_valid}, 64'd0);
    seen = 0;
    repeat (20) begin tick(); if (out_valid) seen++; end
    check_val("stall_no_extra", 64'(seen), 64'd0);

    // Reset mid-round aborts the block
    in_key = K1; in_data = C1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check_val("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check_val("abort_in_ready", {63'b0, in_ready}, 64'd1);
    check_val("abort_out_data", out_data, 64'd0);
    tick();
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (20) begin tick(); if (out_valid) seen++; end
    check_val("abort_no_result", 64'(seen), 64'd0);
    xfer(K1, C1, 0, res, lat);
    check_val("abort_next_data", res, P1);
    check_val("abort_next_latency", 64'(lat), 64'd16);

    // Back-to-back with in_valid and out_ready held high
    out_ready = 1'b1;
    in_key = K1; in_data = C1; in_valid = 1'b1;
    nacc = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = in_valid && in_ready;
      if (out_valid) begin res_q.push_back(out_data); cyc_q.push_back(cyc); end
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) begin in_key = K2; in_data = C2; end
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_val("b2b_count", 64'(res_q.size()), 64'd2);
    check_val("b2b_first", (res_q.size() > 0) ? res_q[0] : 64'hx, P1);
    check_val("b2b_second", (res_q.size() > 1) ? res_q[1] : 64'hx, P2);
    check_val("b2b_spacing", (cyc_q.size() > 1) ? 64'(cyc_q[1] - cyc_q[0]) : 64'hx, 64'd18);

    // Random vectors against the reference model
    for (int v = 0; v < 1000; v++) begin
      k  = {$urandom, $urandom};
      dt = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) tick();
      xfer(k, dt, $urandom_range(0, 3), res, lat);
      exp = des_model(k, dt, 1'b1);
      check_val("rand_decrypt", res, exp);
      check_val("rand_roundtrip", des_model(k, res, 1'b0), dt);
      check_val("rand_latency", 64'(lat), 64'd16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
